// File: rtl/ecc_pkg.sv
// secp256k1 field constants, FSM state encoding and single-correction field add/sub.
// Field elements travel as W+2 bit words so carries never need a separate bit.
package ecc_pkg;
    localparam int W  = 256;
    localparam int CW = $clog2(W + 2);
    localparam logic [W-1:0] P       = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [W-1:0] CURVE_B = 256'd7;

    typedef logic [W+1:0] fe_t;

    localparam fe_t PP  = {2'b00, P};
    localparam fe_t P2X = {1'b0, P, 1'b0};
    localparam fe_t EXP = PP - fe_t'(2);

    typedef enum logic [3:0] {
        IDLE, CHECK, NUM_DEN, INV, LAMBDA, LSQ, X3, Y3MUL, Y3, DONE
    } state_t;

    // Raw coordinates are < 2^256 < 2P, so one subtraction reduces them.
    function automatic fe_t fred(input logic [W-1:0] a);
        fe_t s;
        s = {2'b00, a};
        return (s >= PP) ? s - PP : s;
    endfunction

    function automatic fe_t fadd(input fe_t a, input fe_t b);
        fe_t s;
        s = a + b;
        return (s >= PP) ? s - PP : s;
    endfunction

    function automatic fe_t fsub(input fe_t a, input fe_t b);
        return (a >= b) ? a - b : a + PP - b;
    endfunction
endpackage

// File: rtl/fp_mul.sv
// Bit-serial interleaved modular multiplier, r = a*b mod P, MSB of a first.
// done pulses W+2 cycles after the start cycle; operands must already be < P.
module fp_mul
    import ecc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W+1:0] a,
    input  logic [W+1:0] b,
    output logic         done,
    output logic [W+1:0] r
);
    typedef enum logic [1:0] {M_IDLE, M_RUN, M_FIN} mstate_t;

    mstate_t        st, st_nx;
    fe_t            ar, br, acc, prod, step;
    logic [CW-1:0]  cnt;

    // 2*acc + b < 3P, so at most one of 2P / P needs removing.
    always_comb begin
        prod = (acc << 1) + (ar[cnt] ? br : '0);
        if (prod >= P2X)     step = prod - P2X;
        else if (prod >= PP) step = prod - PP;
        else                 step = prod;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= M_IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            M_IDLE:  if (start) st_nx = M_RUN;
            M_RUN:   if (cnt == '0) st_nx = M_FIN;
            default: st_nx = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar   <= '0;
            br   <= '0;
            acc  <= '0;
            cnt  <= '0;
            done <= 1'b0;
            r    <= '0;
        end else begin
            done <= 1'b0;
            case (st)
                M_IDLE: if (start) begin
                    ar  <= a;
                    br  <= b;
                    acc <= '0;
                    cnt <= CW'(W - 1);
                end
                M_RUN: begin
                    acc <= step;
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                M_FIN: begin
                    r    <= acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ec_point_add.sv
// Affine secp256k1 point adder R = P1 + P2 with one shared multiplier;
// the slope denominator is inverted by Fermat exponentiation den^(P-2).
module ec_point_add
    import ecc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    input  logic         inf1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] y2,
    input  logic         inf2,
    output logic         done,
    output logic [W-1:0] x3,
    output logic [W-1:0] y3,
    output logic         inf3
);
    state_t         state, state_nx;
    fe_t            x1r, y1r, x2r, y2r, num, den, acc, lam, t, xr, y3n;
    fe_t            ma, mb, mr;
    logic           i1, i2, dbl, sq, mpend;
    logic [CW-1:0]  ebit;
    logic           mul_start, mul_done, mul_state, inv_last, triv, rinf;
    logic [W-1:0]   rx, ry;
    logic [1:0]     unused_hi;

    assign done      = (state == DONE);
    assign y3n       = fsub(t, y1r);
    assign unused_hi = y3n[W+1:W];

    // Trivial outcomes: any infinity operand, or P2 = -P1 (including y = 0 doubling).
    assign triv = i1 || i2 || (x1r == x2r && (y1r != y2r || y1r == '0));
    assign rinf = (i1 == i2);
    assign rx   = rinf ? '0 : (i1 ? x2r[W-1:0] : x1r[W-1:0]);
    assign ry   = rinf ? '0 : (i1 ? y2r[W-1:0] : y1r[W-1:0]);

    // Exponent scan ends after the last bit's square, plus its multiply when the bit is set.
    assign inv_last  = (ebit == '0) && !(sq && EXP[ebit]);
    assign mul_state = (state == NUM_DEN && dbl) || (state inside {INV, LAMBDA, LSQ, Y3MUL});
    assign mul_start = mul_state && !mpend;

    always_comb begin
        ma = acc;
        mb = acc;
        case (state)
            NUM_DEN: begin ma = x1r; mb = x1r; end
            INV:     mb = sq ? acc : den;
            LAMBDA:  begin ma = num; mb = acc; end
            LSQ:     begin ma = lam; mb = lam; end
            Y3MUL:   begin ma = lam; mb = fsub(x1r, xr); end
            default: ;
        endcase
    end

    fp_mul u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (ma),
        .b     (mb),
        .done  (mul_done),
        .r     (mr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CHECK;
            CHECK:   state_nx = triv ? DONE : NUM_DEN;
            NUM_DEN: if (!dbl || mul_done) state_nx = INV;
            INV:     if (mul_done && inv_last) state_nx = LAMBDA;
            LAMBDA:  if (mul_done) state_nx = LSQ;
            LSQ:     if (mul_done) state_nx = X3;
            X3:      state_nx = Y3MUL;
            Y3MUL:   if (mul_done) state_nx = Y3;
            Y3:      state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {x1r, y1r, x2r, y2r} <= '0;
            {num, den, acc, lam, t, xr} <= '0;
            {i1, i2, dbl, sq, mpend} <= '0;
            ebit <= '0;
            x3   <= '0;
            y3   <= '0;
            inf3 <= 1'b0;
        end else begin
            if (mul_start)     mpend <= 1'b1;
            else if (mul_done) mpend <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x1r <= fred(x1);
                    y1r <= fred(y1);
                    x2r <= fred(x2);
                    y2r <= fred(y2);
                    i1  <= inf1;
                    i2  <= inf2;
                end
                CHECK: begin
                    dbl <= (x1r == x2r);
                    if (triv) begin
                        x3   <= rx;
                        y3   <= ry;
                        inf3 <= rinf;
                    end
                end
                NUM_DEN: begin
                    sq   <= 1'b1;
                    ebit <= CW'(W - 2);
                    if (!dbl) begin
                        num <= fsub(y2r, y1r);
                        den <= fsub(x2r, x1r);
                        acc <= fsub(x2r, x1r);
                    end else if (mul_done) begin
                        num <= fadd(fadd(mr, mr), mr);
                        den <= fadd(y1r, y1r);
                        acc <= fadd(y1r, y1r);
                    end
                end
                INV: if (mul_done) begin
                    acc <= mr;
                    if (sq && EXP[ebit]) begin
                        sq <= 1'b0;
                    end else begin
                        sq   <= 1'b1;
                        ebit <= ebit - CW'(1);
                    end
                end
                LAMBDA: if (mul_done) lam <= mr;
                LSQ:    if (mul_done) t <= mr;
                X3:     xr <= fsub(fsub(t, x1r), x2r);
                Y3MUL:  if (mul_done) t <= mr;
                Y3: begin
                    x3   <= xr[W-1:0];
                    y3   <= y3n[W-1:0];
                    inf3 <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ec_point_add.sv
// Directed vectors for ec_point_add: identities, inverse, reset abort, doubling of G
// and a general add with a stray start pulse injected while busy.
module tb_ec_point_add;
    localparam logic [255:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [255:0] GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    localparam logic [255:0] GYN = P - GY;
    localparam logic [255:0] AX1 = 256'hC48DABA7B27AB5C595B73AEE10876E8A11D1EC1F67B7E33D5A492E24818CCDF7;
    localparam logic [255:0] AY1 = 256'h7C9BC7B7CDADCAA5325DC4D4953FF2A82A2D7AB0BE2C7B692A487248BAB8EC48;
    localparam logic [255:0] AX2 = 256'h954FCF916816263A4645F192CF54E79DAF476AC620639DF7800F4A23ABD3FE87;
    localparam logic [255:0] AY2 = 256'h5FB35F6BF09803384C6B14BB58DD8D9D8658DAE8DAFB76DD11F8622A139BBCE0;
    localparam logic [255:0] AX3 = 256'hDFED5FA88334F4C3A78EF0598249397CBFC05F9A80A15629DF8F00868B6D2B0A;
    localparam logic [255:0] AY3 = 256'hE14B29F022BD91999B61A06732E4CB8DB28074264B31CA70882428DE6CDD79C4;
    localparam logic [255:0] DX3 = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
    localparam logic [255:0] DY3 = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
    localparam int LIMIT = 150000;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [255:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic         inf1 = 1'b0, inf2 = 1'b0;
    logic         done, inf3;
    logic [255:0] x3, y3;
    int           nchk = 0, nerr = 0, done_cnt = 0, lat, d0;

    ec_point_add dut (
        .clk (clk), .rst (rst), .start (start),
        .x1 (x1), .y1 (y1), .inf1 (inf1),
        .x2 (x2), .y2 (y2), .inf2 (inf2),
        .done (done), .x3 (x3), .y3 (y3), .inf3 (inf3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Launch one operation, scramble the inputs afterwards, optionally pulse start again at cycle poke.
    task automatic run_op(input logic [255:0] ax1, input logic [255:0] ay1, input logic ai1,
                          input logic [255:0] ax2, input logic [255:0] ay2, input logic ai2,
                          input int poke, output int n);
        @(negedge clk);
        x1 = ax1; y1 = ay1; inf1 = ai1;
        x2 = ax2; y2 = ay2; inf2 = ai2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; inf1 = 1'b0; inf2 = 1'b0;
        n = 1;
        while (!done && n < LIMIT) begin
            start = (poke != 0 && n == poke);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_seen", {255'b0, done}, 256'd1);
    endtask

    task automatic chk_hold(input string tag, input logic [255:0] ex, input logic [255:0] ey, input logic ei);
        @(negedge clk);
        chk({tag, "_pulse"}, {255'b0, done}, 256'd0);
        x1 = ~GX; y1 = ~GY; start = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, "_hold_x"}, x3, ex);
        chk({tag, "_hold_y"}, y3, ey);
        chk({tag, "_hold_inf"}, {255'b0, inf3}, {255'b0, ei});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_done", {255'b0, done}, 256'd0);
        chk("rst_x3", x3, 256'd0);
        chk("rst_y3", y3, 256'd0);
        chk("rst_inf3", {255'b0, inf3}, 256'd0);
        rst = 1'b0;

        run_op(AX1, AY1, 1'b1, GX, GY, 1'b0, 0, lat);
        chk("inf1_lat", lat, 256'd2);
        chk("inf1_x", x3, GX);
        chk("inf1_y", y3, GY);
        chk("inf1_inf", {255'b0, inf3}, 256'd0);
        chk_hold("inf1", GX, GY, 1'b0);

        run_op(GX, GY, 1'b0, AX2, AY2, 1'b1, 0, lat);
        chk("inf2_lat", lat, 256'd2);
        chk("inf2_x", x3, GX);
        chk("inf2_y", y3, GY);
        chk("inf2_inf", {255'b0, inf3}, 256'd0);

        run_op(GX, GY, 1'b1, AX2, AY2, 1'b1, 0, lat);
        chk("both_x", x3, 256'd0);
        chk("both_y", y3, 256'd0);
        chk("both_inf", {255'b0, inf3}, 256'd1);

        run_op(AX1, AY1, 1'b0, AX1, AY1, 1'b0, 0, lat);
        run_op(GX, GY, 1'b0, GX, GYN, 1'b0, 0, lat);
        chk("neg_lat", lat, 256'd2);
        chk("neg_x", x3, 256'd0);
        chk("neg_y", y3, 256'd0);
        chk("neg_inf", {255'b0, inf3}, 256'd1);

        // Abort a general add part-way through with reset.
        @(negedge clk);
        x1 = AX1; y1 = AY1; x2 = AX2; y2 = AY2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done_cnt;
        repeat (2000) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_done", {255'b0, done}, 256'd0);
        chk("abort_x", x3, 256'd0);
        chk("abort_y", y3, 256'd0);
        chk("abort_inf", {255'b0, inf3}, 256'd0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("abort_nopulse", done_cnt, d0);

        run_op(GX, GY, 1'b0, GX, GY, 1'b0, 0, lat);
        chk("dbl_x", x3, DX3);
        chk("dbl_y", y3, DY3);
        chk("dbl_inf", {255'b0, inf3}, 256'd0);
        chk_hold("dbl", DX3, DY3, 1'b0);

        d0 = done_cnt;
        run_op(AX1, AY1, 1'b0, AX2, AY2, 1'b0, 1000, lat);
        chk("add_x", x3, AX3);
        chk("add_y", y3, AY3);
        chk("add_inf", {255'b0, inf3}, 256'd0);
        chk_hold("add", AX3, AY3, 1'b0);
        chk("add_one_done", done_cnt - d0, 256'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
